// File: rtl/trivium_host_ctrl.sv
// Host-side sequencer for a Trivium stream-cipher core.
// Takes a host request, loads the key (only when needed) and the IV into the
// core, waits for the keystream block, and holds it for the host until it is
// acknowledged. A per-state wait counter aborts any stalled handshake and
// raises a sticky error flag.
module trivium_host_ctrl #(
    parameter int TIMEOUT = 4096,
    parameter int KEY_W   = 80
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             KeyNew,
    input  logic [KEY_W-1:0] Kin,
    input  logic [KEY_W-1:0] IVin,
    output logic             Idle,
    output logic [127:0]     Rdata,
    output logic             Rvld,
    input  logic             Rack,
    output logic             Err,
    output logic [KEY_W-1:0] C_Kin,
    output logic [KEY_W-1:0] C_Din,
    output logic             C_Krdy,
    output logic             C_Drdy,
    output logic             C_EN,
    output logic             C_EncDec,
    input  logic [127:0]     C_Dout,
    input  logic             C_BSY,
    input  logic             C_Kvld,
    input  logic             C_Dvld
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDKEY,
        S_LDIV,
        S_RUN,
        S_OUT
    } state_t;

    state_t           state;
    logic [CW-1:0]    wait_cnt;
    logic             key_loaded;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] iv_reg;
    logic             timed_out;

    // The current wait state has used up its cycle budget.
    assign timed_out = (wait_cnt == LAST);

    // Key and IV buses are only driven while the matching ready is up, so the
    // core never sees stale secrets outside its load window.
    assign C_Kin    = C_Krdy ? key_reg : '0;
    assign C_Din    = C_Drdy ? iv_reg : '0;
    assign C_EncDec = 1'b0;

    // Main sequencer: state, wait counter and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            Idle       <= 1'b1;
            Rvld       <= 1'b0;
            Err        <= 1'b0;
            Rdata      <= '0;
            C_Krdy     <= 1'b0;
            C_Drdy     <= 1'b0;
            C_EN       <= 1'b0;
            wait_cnt   <= '0;
            key_loaded <= 1'b0;
            key_reg    <= '0;
            iv_reg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        key_reg  <= Kin;
                        iv_reg   <= IVin;
                        Err      <= 1'b0;
                        Idle     <= 1'b0;
                        C_EN     <= 1'b1;
                        wait_cnt <= '0;
                        if (KeyNew || !key_loaded) begin
                            state  <= S_LDKEY;
                            C_Krdy <= 1'b1;
                        end else begin
                            state  <= S_LDIV;
                            C_Drdy <= 1'b1;
                        end
                    end
                end
                S_LDKEY: begin
                    if (C_Kvld) begin
                        C_Krdy     <= 1'b0;
                        C_Drdy     <= 1'b1;
                        key_loaded <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= S_LDIV;
                    end else if (timed_out) begin
                        C_Krdy     <= 1'b0;
                        Err        <= 1'b1;
                        key_loaded <= 1'b0;
                        Idle       <= 1'b1;
                        C_EN       <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_LDIV: begin
                    if (C_BSY) begin
                        C_Drdy   <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_RUN;
                    end else if (timed_out) begin
                        C_Drdy     <= 1'b0;
                        Err        <= 1'b1;
                        key_loaded <= 1'b0;
                        Idle       <= 1'b1;
                        C_EN       <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (C_Dvld) begin
                        Rdata    <= C_Dout;
                        Rvld     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_OUT;
                    end else if (timed_out) begin
                        Err        <= 1'b1;
                        key_loaded <= 1'b0;
                        Idle       <= 1'b1;
                        C_EN       <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (Rack) begin
                        Rvld     <= 1'b0;
                        Idle     <= 1'b1;
                        C_EN     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Idle  <= 1'b1;
                    C_EN  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_host_ctrl.sv
// Self-checking bench for trivium_host_ctrl: one instance with the default
// timeout for long core latencies, one with TIMEOUT=16 for timeout corners.
module tb_trivium_host_ctrl;

    localparam int T_SMALL = 16;

    typedef struct {
        int          kcyc;
        int          dcyc;
        int          first_d;
        int          rv_cyc;
        logic        got_rvld;
        logic [127:0] got_rdata;
        int          bad;
    } obs_t;

    typedef struct {
        bit kn;
        int lk;
        int lb;
        int ld;
        int rdly;
        int ek;
        int ed;
        bit erv;
        bit eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic         start  [2];
    logic         keynew [2];
    logic         rack   [2];
    logic [79:0]  kin    [2];
    logic [79:0]  ivin   [2];
    logic         idle   [2];
    logic [127:0] rdata  [2];
    logic         rvld   [2];
    logic         err    [2];
    logic [79:0]  ckin   [2];
    logic [79:0]  cdin   [2];
    logic         krdy   [2];
    logic         drdy   [2];
    logic         en     [2];
    logic         encdec [2];
    logic [127:0] cdout  [2];
    logic         bsy    [2];
    logic         kvld   [2];
    logic         dvld   [2];
    logic         kx     [2];
    logic         bx     [2];
    logic         dx     [2];
    int           lat_k  [2];
    int           lat_b  [2];
    int           lat_d  [2];

    bit           loaded_m [2];
    logic [127:0] rdata_m  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trivium_host_ctrl #(.TIMEOUT(4096), .KEY_W(80)) dut0 (
        .CLK(clk), .RST(rst), .Start(start[0]), .KeyNew(keynew[0]),
        .Kin(kin[0]), .IVin(ivin[0]), .Idle(idle[0]), .Rdata(rdata[0]),
        .Rvld(rvld[0]), .Rack(rack[0]), .Err(err[0]), .C_Kin(ckin[0]),
        .C_Din(cdin[0]), .C_Krdy(krdy[0]), .C_Drdy(drdy[0]), .C_EN(en[0]),
        .C_EncDec(encdec[0]), .C_Dout(cdout[0]), .C_BSY(bsy[0]),
        .C_Kvld(kvld[0]), .C_Dvld(dvld[0])
    );

    trivium_host_ctrl #(.TIMEOUT(T_SMALL), .KEY_W(80)) dut1 (
        .CLK(clk), .RST(rst), .Start(start[1]), .KeyNew(keynew[1]),
        .Kin(kin[1]), .IVin(ivin[1]), .Idle(idle[1]), .Rdata(rdata[1]),
        .Rvld(rvld[1]), .Rack(rack[1]), .Err(err[1]), .C_Kin(ckin[1]),
        .C_Din(cdin[1]), .C_Krdy(krdy[1]), .C_Drdy(drdy[1]), .C_EN(en[1]),
        .C_EncDec(encdec[1]), .C_Dout(cdout[1]), .C_BSY(bsy[1]),
        .C_Kvld(kvld[1]), .C_Dvld(dvld[1])
    );

    // Core models: each handshake answers a programmable number of cycles
    // after its ready rises; kx/bx/dx inject spurious status pulses.
    for (genvar g = 0; g < 2; g++) begin : core
        int   kc = 0;
        int   bc = 0;
        int   rc = 0;
        logic running = 1'b0;

        always @(posedge clk) begin
            kc <= krdy[g] ? kc + 1 : 0;
            bc <= drdy[g] ? bc + 1 : 0;
            if (rst || !en[g]) begin
                running <= 1'b0;
            end else if (drdy[g] && bsy[g]) begin
                running <= 1'b1;
                rc      <= 0;
            end else if (running) begin
                if (dvld[g]) running <= 1'b0;
                rc <= rc + 1;
            end
        end

        assign kvld[g] = (krdy[g] && kc == lat_k[g]) || kx[g];
        assign bsy[g]  = (drdy[g] && bc == lat_b[g]) || bx[g];
        assign dvld[g] = (running && rc == lat_d[g]) || dx[g];
    end

    function automatic logic [79:0] rnd80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: a phase succeeds if its event latency fits in T cycles; a
    // failing phase holds its ready for exactly T cycles and ends the request.
    function automatic void predict(input int t, input bit loaded, input bit kn,
                                    input int lk, input int lb, input int ld,
                                    output int ek, output int ed, output bit ok);
        ek = 0;
        ed = 0;
        ok = 1'b1;
        if (kn || !loaded) begin
            ek = (lk < t) ? lk + 1 : t;
            ok = (lk < t);
        end
        if (ok) begin
            ed = (lb < t) ? lb + 1 : t;
            ok = (lb < t) && (ld < t);
        end
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Issue one request on instance u and observe it until the controller is
    // idle again, recording handshake lengths and any protocol violation.
    task automatic apply_stimulus(input int u, input bit kn, input logic [79:0] k,
                                  input logic [79:0] iv, input int lk, input int lb,
                                  input int ld, input logic [127:0] dout,
                                  input int rdly, input bit noise, output obs_t o);
        bit done;
        lat_k[u] = lk;
        lat_b[u] = lb;
        lat_d[u] = ld;
        cdout[u] = dout;
        start[u] = 1'b1;
        keynew[u] = kn;
        kin[u] = k;
        ivin[u] = iv;
        @(negedge clk);
        start[u] = 1'b0;
        kin[u] = rnd80();
        ivin[u] = rnd80();
        keynew[u] = 1'($urandom_range(0, 1));
        o.kcyc = 0;
        o.dcyc = 0;
        o.first_d = -1;
        o.rv_cyc = 0;
        o.got_rvld = 1'b0;
        o.got_rdata = '0;
        o.bad = 0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            start[u] = 1'b0;
            rack[u] = 1'b0;
            if (krdy[u]) begin
                o.kcyc++;
                if (ckin[u] !== k) o.bad++;
            end else if (ckin[u] !== '0) o.bad++;
            if (drdy[u]) begin
                if (o.first_d < 0) o.first_d = c;
                o.dcyc++;
                if (cdin[u] !== iv) o.bad++;
            end else if (cdin[u] !== '0) o.bad++;
            if (encdec[u] !== 1'b0) o.bad++;
            if (idle[u]) begin
                done = 1'b1;
                if (en[u] !== 1'b0 || rvld[u] !== 1'b0) o.bad++;
            end else begin
                if (en[u] !== 1'b1 || err[u] !== 1'b0) o.bad++;
                if (rvld[u]) begin
                    if (!o.got_rvld) begin
                        o.got_rvld = 1'b1;
                        o.got_rdata = rdata[u];
                    end else if (rdata[u] !== o.got_rdata) o.bad++;
                    o.rv_cyc++;
                    rack[u] = (o.rv_cyc > rdly);
                    if (noise) cdout[u] = rnd128();
                end
                if (noise && $urandom_range(0, 3) == 0) begin
                    start[u] = 1'b1;
                    kin[u] = rnd80();
                    ivin[u] = rnd80();
                    keynew[u] = 1'b1;
                end
                @(negedge clk);
            end
        end
        start[u] = 1'b0;
        rack[u] = 1'b0;
        if (!done) o.bad += 1000;
    endtask

    // Compare an observed request against expectations and advance the
    // per-instance key-loaded and result models.
    task automatic check_output(input string name, input int u, input obs_t o,
                                input int ek, input int ed, input bit ok,
                                input logic [127:0] dout);
        if (ok) rdata_m[u] = dout;
        loaded_m[u] = ok;
        chk({name, "_krdy_cycles"}, 128'(o.kcyc), 128'(ek));
        chk({name, "_drdy_cycles"}, 128'(o.dcyc), 128'(ed));
        chk({name, "_rvld_seen"}, 128'(o.got_rvld), 128'(ok));
        if (ok) chk({name, "_rdata_at_rvld"}, o.got_rdata, dout);
        chk({name, "_err"}, 128'(err[u]), 128'(!ok));
        chk({name, "_rdata_final"}, rdata[u], rdata_m[u]);
        chk({name, "_protocol_violations"}, 128'(o.bad), 128'(0));
    endtask

    task automatic check_reset_state(input string name, input int u);
        chk({name, "_idle"}, 128'(idle[u]), 128'(1));
        chk({name, "_rvld"}, 128'(rvld[u]), 128'(0));
        chk({name, "_err"}, 128'(err[u]), 128'(0));
        chk({name, "_rdata"}, rdata[u], 128'(0));
        chk({name, "_ctl"}, 128'({krdy[u], drdy[u], en[u], encdec[u]}), 128'(0));
        chk({name, "_buses"}, 128'({ckin[u], cdin[u]}), 128'(0));
    endtask

    vec_t vecs [9];

    initial begin
        obs_t o;
        int ek, ed;
        bit ok;
        logic [127:0] dout;
        logic [79:0] kk;
        bit kn;
        int lk, lb, ld;

        vecs[0] = '{0, 3, 1, 5, 0,  4,  2, 1, 0};
        vecs[1] = '{0, 3, 0, 2, 1,  0,  1, 1, 0};
        vecs[2] = '{1, 40, 0, 0, 0, 16, 0, 0, 1};
        vecs[3] = '{0, 2, 2, 0, 2,  3,  3, 1, 0};
        vecs[4] = '{1, 15, 15, 15, 0, 16, 16, 1, 0};
        vecs[5] = '{0, 0, 16, 0, 0,  0, 16, 0, 1};
        vecs[6] = '{0, 0, 0, 16, 0,  1,  1, 0, 1};
        vecs[7] = '{0, 1, 1, 15, 3,  2,  2, 1, 0};
        vecs[8] = '{1, 0, 3, 3, 0,   1,  4, 1, 0};

        for (int u = 0; u < 2; u++) begin
            start[u] = 0; keynew[u] = 0; rack[u] = 0; kin[u] = '0; ivin[u] = '0;
            cdout[u] = '0; kx[u] = 0; bx[u] = 0; dx[u] = 0;
            lat_k[u] = 0; lat_b[u] = 0; lat_d[u] = 0;
            loaded_m[u] = 0; rdata_m[u] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset0", 0);
        check_reset_state("reset1", 1);

        // Table vectors on the short-timeout instance.
        for (int i = 0; i < 9; i++) begin
            dout = rnd128();
            kk = rnd80();
            apply_stimulus(1, vecs[i].kn, kk, rnd80(), vecs[i].lk, vecs[i].lb,
                           vecs[i].ld, dout, vecs[i].rdly, 1'b1, o);
            check_output($sformatf("vec%0d", i), 1, o, vecs[i].ek, vecs[i].ed,
                         vecs[i].erv, dout);
        end

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            kn = 1'($urandom_range(0, 1));
            lk = $urandom_range(0, 18);
            lb = $urandom_range(0, 18);
            ld = $urandom_range(0, 18);
            dout = rnd128();
            predict(T_SMALL, loaded_m[1], kn, lk, lb, ld, ek, ed, ok);
            apply_stimulus(1, kn, rnd80(), rnd80(), lk, lb, ld, dout,
                           $urandom_range(0, 3), 1'b1, o);
            check_output($sformatf("rnd%0d", i), 1, o, ek, ed, ok, dout);
        end

        // Cold start: key loaded even though KeyNew=0.
        dout = rnd128();
        apply_stimulus(0, 1'b0, 80'h0, 80'h00010203040506070809, 3, 1, 1151,
                       dout, 0, 1'b0, o);
        check_output("cold", 0, o, 4, 2, 1'b1, dout);
        chk("cold_rvld_one_cycle", 128'(o.rv_cyc), 128'(1));

        // Key reuse: straight to IV load on the cycle after Start.
        dout = rnd128();
        apply_stimulus(0, 1'b0, rnd80(), rnd80(), 3, 1, 10, dout, 0, 1'b0, o);
        check_output("reuse", 0, o, 0, 2, 1'b1, dout);
        chk("reuse_drdy_first", 128'(o.first_d), 128'(0));

        // Back-pressure with changing core output and stray Start pulses.
        dout = rnd128();
        apply_stimulus(0, 1'b0, rnd80(), rnd80(), 0, 0, 4, dout, 20, 1'b1, o);
        check_output("bp", 0, o, 0, 1, 1'b1, dout);
        chk("bp_rvld_cycles", 128'(o.rv_cyc), 128'(21));

        // Stray Kvld/Dvld outside their wait states must not advance anything.
        kx[0] = 1'b1;
        dx[0] = 1'b1;
        dout = rnd128();
        apply_stimulus(0, 1'b0, rnd80(), rnd80(), 0, 5, 0, dout, 0, 1'b0, o);
        kx[0] = 1'b0;
        dx[0] = 1'b0;
        check_output("stray", 0, o, 0, 6, 1'b1, dout);

        // Reset while waiting for Dvld.
        lat_b[0] = 0;
        lat_d[0] = 100000;
        start[0] = 1'b1;
        keynew[0] = 1'b0;
        kin[0] = rnd80();
        ivin[0] = rnd80();
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("run_pre_state", 128'({idle[0], en[0], drdy[0], krdy[0]}), 128'(4'b0100));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("run_reset", 0);
        for (int u = 0; u < 2; u++) begin
            loaded_m[u] = 0;
            rdata_m[u] = '0;
        end

        // Reset wins over Start on the same edge.
        start[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_vs_start", 128'({idle[0], krdy[0], drdy[0]}), 128'(3'b100));

        dout = rnd128();
        apply_stimulus(0, 1'b0, rnd80(), rnd80(), 2, 1, 3, dout, 0, 1'b0, o);
        check_output("post_reset", 0, o, 3, 2, 1'b1, dout);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trivium_host_ctrl.md
TRIVIUM_HOST_CTRL -- requirements
Module: trivium_host_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 4096: maximum cycles permitted in any single core-wait state.
REQ-002 Parameter KEY_W, default 80: key and IV width.
REQ-003 CLK  in  1  system clock; one clock domain, all logic on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 Start  in  1  host request; a one-cycle pulse is sufficient.
REQ-006 KeyNew  in  1  sampled with Start; 1 = load Kin into the core before the IV.
REQ-007 Kin  in  KEY_W  key, sampled with Start.
REQ-008 IVin  in  KEY_W  IV, sampled with Start.
REQ-009 Idle  out  1  controller ready to accept Start.
REQ-010 Rdata  out  128  captured core output.
REQ-011 Rvld  out  1  Rdata valid; held until Rack.
REQ-012 Rack  in  1  host acknowledge of Rdata.
REQ-013 Err  out  1  sticky timeout flag.
REQ-014 C_Kin, C_Din  out  KEY_W  key and IV driven to the core.
REQ-015 C_Krdy, C_Drdy, C_EN, C_EncDec  out  1  core controls.
REQ-016 C_Dout  in  128; C_BSY, C_Kvld, C_Dvld  in  1  core status.

Function
REQ-017 States SHALL be IDLE, LDKEY, LDIV, RUN and OUT, with Idle=1 only in IDLE.
REQ-018 In IDLE, Start=1 SHALL register Kin, IVin and KeyNew and clear Err.
REQ-019 From IDLE on Start: go to LDKEY if KeyNew=1 or no key has been loaded since reset; otherwise go to LDIV.
REQ-020 LDKEY: C_Krdy=1 and C_Kin=key register; on the first cycle C_Kvld=1, deassert C_Krdy on the next edge, set the key-loaded flag and go to LDIV.
REQ-021 LDIV: C_Drdy=1 and C_Din=IV register; on the first cycle C_BSY=1, deassert C_Drdy and go to RUN.
REQ-022 RUN: on the first cycle C_Dvld=1, capture C_Dout into Rdata and go to OUT; Rvld=1 from the next cycle.
REQ-023 OUT: hold Rvld and Rdata stable until Rack=1, then clear Rvld on that edge and go to IDLE.
REQ-024 Rack=1 on the first cycle Rvld=1 SHALL be honoured, giving a one-cycle Rvld.
REQ-025 C_EN SHALL be 1 in every state other than IDLE.
REQ-026 C_EncDec SHALL be constant 0.
REQ-027 C_Kin and C_Din SHALL be 0 whenever their respective ready signal is 0.
REQ-028 Start outside IDLE SHALL be ignored, with no effect on the registered inputs.
REQ-029 Wait counter:
- cleared on every state entry;
- increments each cycle in LDKEY, LDIV and RUN;
- reaching TIMEOUT-1 without the awaited event: drop C_Krdy and C_Drdy, set Err=1, clear the key-loaded flag, go to IDLE; Rvld stays 0.
REQ-030 An awaited event on the same cycle the counter reaches TIMEOUT-1 SHALL win: normal transition, no Err.
REQ-031 C_Dvld or C_Kvld outside its wait state SHALL be ignored.
REQ-032 C_BSY=1 already present on LDIV entry SHALL count as the event on that first cycle.

Reset
REQ-033 RST=1 at any edge, including mid-operation, SHALL force:
- state IDLE;
- Idle=1;
- Rvld=0, Err=0, Rdata=0;
- C_Krdy=0, C_Drdy=0, C_EN=0, C_Kin=0, C_Din=0;
- wait counter 0;
- key-loaded flag 0.
REQ-034 RST SHALL take priority over Start and over all core events on the same edge.

Verification
REQ-035 Cold start: Start with KeyNew=0, Kin=0, IVin=80'h00010203040506070809; core model asserts Kvld 3 cycles and BSY 1 cycle after ready, Dvld 1152 cycles after BSY -> LDKEY is entered despite KeyNew=0, then Rvld=1 one cycle after Dvld with Rdata=model C_Dout, and Idle=1 after Rack.
REQ-036 Key reuse: second Start with KeyNew=0 -> C_Krdy never asserts, C_Drdy asserts one cycle after Start, and the result is correct.
REQ-037 Timeout: core never asserts Kvld with TIMEOUT=16 -> C_Krdy drops after 16 cycles, Err=1, Idle=1, Rvld=0; the next Start clears Err and reloads the key.
REQ-038 Boundary: Kvld arrives on the cycle the counter reaches TIMEOUT-1 -> no Err, LDIV entered.
REQ-039 Back-pressure: Rack held 0 for 20 cycles while C_Dout changes and Start pulses -> Rdata unchanged, Start ignored; Rack=1 gives Rvld=0 on the next cycle.
REQ-040 Reset in RUN: RST pulsed while waiting for Dvld -> all outputs at reset values on the next cycle, and the following Start enters LDKEY.
